// File: rtl/inv_gamma_correct.sv
// Inverse Bezier gamma stage: a build FSM sweeps the forward curve F(k) into a 256-entry inverse LUT,
// then three channels are linearized by table lookup. Define INV_GAMMA_AUTO_REBUILD_EN to rebuild on any P1/P2 change.
module inv_gamma_correct (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [9:0] P1,
    input  logic [9:0] P2,
    input  logic       REBUILD,
    input  logic       DI_VALID,
    input  logic [7:0] DI_0,
    input  logic [7:0] DI_1,
    input  logic [7:0] DI_2,
    output logic       DO_VALID,
    output logic [7:0] DO_0,
    output logic [7:0] DO_1,
    output logic [7:0] DO_2,
    output logic       READY
);

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_FILL, S_TAIL} state_t;

    state_t      state, state_nxt;
    logic [7:0]  k;
    logic [8:0]  v;          // v = 256 marks every table entry as written
    logic [1:0]  eval_cnt;
    logic [9:0]  p1_sh, p2_sh;
    logic [7:0]  f_k;
    logic        ready_q;

    logic        build_req, fill_ok, tbl_we, v_inc, k_inc, build_done;
    logic [7:0]  tbl_wdata;

    logic [35:0] u_ext, k_ext, p1_ext, p2_ext;
    logic [35:0] term_a, term_b, term_c, curve_sum;

    logic [7:0]  inv_tbl [256];

    logic [7:0]  di_r0, di_r1, di_r2;
    logic        di_valid_r, ready_r;

`ifdef INV_GAMMA_AUTO_REBUILD_EN
    assign build_req = REBUILD || (P1 != p1_sh) || (P2 != p2_sh);
`else
    assign build_req = REBUILD;
`endif

    assign u_ext  = 36'(9'd256 - {1'b0, k});
    assign k_ext  = 36'(k);
    assign p1_ext = 36'(p1_sh);
    assign p2_ext = 36'(p2_sh);
    assign READY  = ready_q;

    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        tbl_we     = 1'b0;
        tbl_wdata  = k;
        v_inc      = 1'b0;
        k_inc      = 1'b0;
        build_done = 1'b0;
        fill_ok    = !v[8] && (v[7:0] <= f_k);
        unique case (state)
            S_IDLE: ;
            S_EVAL: if (eval_cnt == 2'd2) state_nxt = S_FILL;
            S_FILL: begin
                if (fill_ok) begin
                    tbl_we = 1'b1;
                    v_inc  = 1'b1;
                end else if (k == 8'hFF) begin
                    state_nxt = S_TAIL;
                end else begin
                    k_inc     = 1'b1;
                    state_nxt = S_EVAL;
                end
            end
            S_TAIL: begin
                if (!v[8]) begin
                    tbl_we    = 1'b1;
                    tbl_wdata = 8'hFF;
                    v_inc     = 1'b1;
                end
                if (v[8] || v[7:0] == 8'hFF) begin
                    state_nxt  = S_IDLE;
                    build_done = 1'b1;
                end
            end
        endcase
        if (build_req) begin
            state_nxt = S_EVAL;
            tbl_we    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= S_EVAL;
            k        <= 8'd0;
            v        <= 9'd0;
            eval_cnt <= 2'd0;
            p1_sh    <= P1;
            p2_sh    <= P2;
            ready_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (build_req) begin
                p1_sh    <= P1;
                p2_sh    <= P2;
                k        <= 8'd0;
                v        <= 9'd0;
                eval_cnt <= 2'd0;
                ready_q  <= 1'b0;
            end else begin
                if (v_inc) v <= v + 9'd1;
                if (k_inc) k <= k + 8'd1;
                if (state == S_EVAL) eval_cnt <= (eval_cnt == 2'd2) ? 2'd0 : eval_cnt + 2'd1;
                if (build_done) ready_q <= 1'b1;
            end
        end
    end

    // Three-cycle evaluation of F(k): Bernstein products, weighted sum, then bits [33:26] (y[9:2] of y = sum >> 24).
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            term_a    <= '0;
            term_b    <= '0;
            term_c    <= '0;
            curve_sum <= '0;
            f_k       <= 8'd0;
        end else if (state == S_EVAL) begin
            unique case (eval_cnt)
                2'd0: begin
                    term_a <= u_ext * u_ext * k_ext;
                    term_b <= u_ext * k_ext * k_ext;
                    term_c <= k_ext * k_ext * k_ext;
                end
                2'd1: curve_sum <= 36'd3 * term_a * p1_ext + 36'd3 * term_b * p2_ext + term_c * 36'd1023;
                2'd2: f_k <= 8'(curve_sum >> 26);
                default: ;
            endcase
        end
    end

    // NOTE: the table is not reset; a build always rewrites all 256 entries before READY is raised.
    always_ff @(posedge CLK) begin
        if (tbl_we) inv_tbl[v[7:0]] <= tbl_wdata;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            di_r0      <= 8'd0;
            di_r1      <= 8'd0;
            di_r2      <= 8'd0;
            di_valid_r <= 1'b0;
            ready_r    <= 1'b0;
            DO_0       <= 8'd0;
            DO_1       <= 8'd0;
            DO_2       <= 8'd0;
            DO_VALID   <= 1'b0;
        end else begin
            di_r0      <= DI_0;
            di_r1      <= DI_1;
            di_r2      <= DI_2;
            di_valid_r <= DI_VALID;
            ready_r    <= ready_q;
            DO_0       <= ready_r ? inv_tbl[di_r0] : di_r0;
            DO_1       <= ready_r ? inv_tbl[di_r1] : di_r1;
            DO_2       <= ready_r ? inv_tbl[di_r2] : di_r2;
            DO_VALID   <= di_valid_r;
        end
    end

endmodule

// File: tb/tb_inv_gamma_correct.sv
// Self-checking bench for inv_gamma_correct: a search-based inverse-curve model predicts every output beat.
module tb_inv_gamma_correct;

    logic       CLK, RESET_N, REBUILD, DI_VALID, DO_VALID, READY;
    logic [9:0] P1, P2;
    logic [7:0] DI_0, DI_1, DI_2, DO_0, DO_1, DO_2;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int model_tbl [256];

    typedef struct {
        bit vld;
        int d0, d1, d2;
    } beat_t;
    beat_t pipe [2];

    inv_gamma_correct dut (
        .CLK(CLK), .RESET_N(RESET_N), .P1(P1), .P2(P2), .REBUILD(REBUILD),
        .DI_VALID(DI_VALID), .DI_0(DI_0), .DI_1(DI_1), .DI_2(DI_2),
        .DO_VALID(DO_VALID), .DO_0(DO_0), .DO_1(DO_1), .DO_2(DO_2), .READY(READY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Forward curve straight from the Bezier formula.
    function automatic int f_model(input int kk, input int p1, input int p2);
        longint u, kl, y;
        logic [63:0] yb;
        kl = longint'(kk);
        u  = 256 - kl;
        y  = (3 * u * u * kl * p1 + 3 * u * kl * kl * p2 + kl * kl * kl * 1023) >>> 24;
        yb = 64'(y);
        return int'(yb[9:2]);
    endfunction

    // Inverse by exhaustive search: smallest k with F(k) >= v, else 255.
    task automatic build_model(input int p1, input int p2);
        int f [256];
        for (int kk = 0; kk < 256; kk++) f[kk] = f_model(kk, p1, p2);
        for (int vv = 0; vv < 256; vv++) begin
            model_tbl[vv] = 255;
            for (int kk = 255; kk >= 0; kk--) if (f[kk] >= vv) model_tbl[vv] = kk;
        end
    endtask

    // Prediction: capture each input beat with the READY seen at that edge.
    always @(posedge CLK) begin
        if (!RESET_N) begin
            pipe[0] = '{vld: 1'b0, d0: 0, d1: 0, d2: 0};
            pipe[1] = '{vld: 1'b0, d0: 0, d1: 0, d2: 0};
        end else begin
            pipe[1]     = pipe[0];
            pipe[0].vld = DI_VALID;
            pipe[0].d0  = READY ? model_tbl[DI_0] : int'(DI_0);
            pipe[0].d1  = READY ? model_tbl[DI_1] : int'(DI_1);
            pipe[0].d2  = READY ? model_tbl[DI_2] : int'(DI_2);
        end
    end

    // Per-cycle comparison against the prediction from two edges earlier.
    always begin
        @(posedge CLK);
        #2;
        if (!RESET_N) begin
            check("rst_do_valid", DO_VALID, 0);
            check("rst_do_0", DO_0, 0);
            check("rst_ready", READY, 0);
        end else begin
            check("do_valid", DO_VALID, pipe[1].vld);
            if (pipe[1].vld) begin
                check("do_0", DO_0, pipe[1].d0);
                check("do_1", DO_1, pipe[1].d1);
                check("do_2", DO_2, pipe[1].d2);
            end
        end
    end

    task automatic wait_ready(input int t0, input string tag);
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(posedge CLK);
            #1;
            if (READY) done = 1;
        end
        check({tag, "_ready_seen"}, done, 1);
        check({tag, "_len_le_1281"}, (cyc - t0) <= 1281, 1);
        check({tag, "_len_ge_1024"}, (cyc - t0) >= 1024, 1);
    endtask

    task automatic pix_check(input int a, input int b, input int c,
                             input int ea, input int eb, input int ec, input string tag);
        @(negedge CLK);
        DI_VALID = 1'b1; DI_0 = 8'(a); DI_1 = 8'(b); DI_2 = 8'(c);
        @(negedge CLK);
        DI_VALID = 1'b0;
        @(posedge CLK);
        #1;
        check({tag, "_valid"}, DO_VALID, 1);
        check({tag, "_ch0"}, DO_0, ea);
        check({tag, "_ch1"}, DO_1, eb);
        check({tag, "_ch2"}, DO_2, ec);
    endtask

    task automatic random_stream(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            DI_VALID = ($urandom_range(0, 3) != 0);
            DI_0 = 8'($urandom); DI_1 = 8'($urandom); DI_2 = 8'($urandom);
        end
        @(negedge CLK);
        DI_VALID = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic request_rebuild(input int p1, input int p2, output int t0);
        @(negedge CLK);
        P1 = 10'(p1); P2 = 10'(p2); REBUILD = 1'b1;
        build_model(p1, p2);
        t0 = cyc + 1;
        @(negedge CLK);
        REBUILD = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        RESET_N = 1'b0; REBUILD = 1'b0; P1 = 10'd341; P2 = 10'd682;
        DI_VALID = 1'b0; DI_0 = 8'd0; DI_1 = 8'd0; DI_2 = 8'd0;

        build_model(341, 682);
        check("pin_f_lin_101", f_model(101, 341, 682), 100);
        check("pin_inv_lin_100", model_tbl[100], 101);
        check("pin_inv_lin_254", model_tbl[254], 255);
        check("pin_inv_lin_255", model_tbl[255], 255);
        check("pin_f_zero_128", f_model(128, 0, 0), 31);

        repeat (3) @(negedge CLK);
        check("reset_do_valid", DO_VALID, 0);
        check("reset_do_2", DO_2, 0);
        check("reset_ready", READY, 0);

        RESET_N = 1'b1;
        t0 = cyc;
        pix_check(10, 20, 30, 10, 20, 30, "bypass");
        check("bypass_ready_low", READY, 0);
        wait_ready(t0, "build_lin");

        pix_check(0, 100, 254, 0, 101, 255, "lin_a");
        pix_check(255, 0, 100, 255, 0, 101, "lin_b");
        random_stream(200);

        request_rebuild(0, 0, t0);
        check("pin_inv_zero_31", model_tbl[31], 127);
        wait_ready(t0, "build_zero");
        for (int i = 0; i < 256; i++) begin
            @(negedge CLK);
            DI_VALID = 1'b1; DI_0 = 8'(i); DI_1 = 8'(255 - i); DI_2 = 8'(i ^ 8'h55);
        end
        @(negedge CLK);
        DI_VALID = 1'b0;
        pix_check(31, 31, 31, 127, 127, 127, "zero_31");

        request_rebuild(500, 900, t0);
        fork
            random_stream(190);
        join
        repeat (5) @(negedge CLK);
        check("restart_ready_low_200", READY, 0);
        request_rebuild(100, 1000, t0);
        check("restart_ready_still_low", READY, 0);
        wait_ready(t0, "build_restart");
        random_stream(300);

        @(negedge CLK);
        P2 = 10'd300;
`ifdef INV_GAMMA_AUTO_REBUILD_EN
        build_model(100, 300);
        t0 = cyc + 1;
        @(posedge CLK);
        #1;
        check("auto_ready_falls", READY, 0);
        wait_ready(t0, "build_auto");
`else
        repeat (20) begin
            @(posedge CLK);
            #1;
            check("noauto_ready_stays", READY, 1);
        end
`endif
        random_stream(200);

        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            DI_VALID = 1'b1; DI_0 = 8'($urandom); DI_1 = 8'($urandom); DI_2 = 8'($urandom);
        end
        @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        check("midrst_do_valid", DO_VALID, 0);
        check("midrst_do_0", DO_0, 0);
        check("midrst_do_1", DO_1, 0);
        check("midrst_ready", READY, 0);
        DI_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        build_model(int'(P1), int'(P2));
        RESET_N = 1'b1;
        t0 = cyc;
        wait_ready(t0, "build_after_rst");
        random_stream(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
